vp_axil_cfg_regbank: RTL and testbench
======================================

Name: vp_axil_cfg_regbank

Overview:
- AXI4-Lite slave register bank at the control port of the videoProcess IP; directly downstream of the AXI master VIP/PS master.
- Holds four 32-bit software-visible shadow registers.
- Transfers them to an active register set on a frame-start pulse, so the video datapath sees only frame-coherent configuration.
- All shadow registers are read/write; readback returns shadow values.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored
NUM_REGS, 4, register count; fixed at 4 for this address width

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte-lane enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
i_frame_start  in  1  single-cycle pulse from the video timing path
o_cfg  out  128  active registers; reg n occupies bits [32n+31:32n]
o_cfg_updated  out  1  one-cycle pulse after each active-set load

Behaviour:
- Reset (ARESET=1 at an edge):
  - Shadow and active registers load 0.
  - BVALID, RVALID, RDATA and o_cfg_updated are 0, and the AW/W held flags are cleared.
  - AWREADY, WREADY and ARREADY are 0 while ARESET=1 and rise the first cycle after it deasserts.
- Reset mid-transaction abandons it; no response is issued.
- Write path: AW and W are accepted independently, in any order.
  - AWREADY = !ARESET & !aw_held & !BVALID.
  - WREADY = !ARESET & !w_held & !BVALID.
  - A handshake on either channel latches its payload and sets its held flag.
- The write commits at the edge where both AW and W are available, each either already held or handshaking that cycle.
  - At that edge, shadow[AWADDR[3:2]] is updated byte-wise per WSTRB; lanes with strobe 0 keep their value.
  - BVALID rises at the same edge and the held flags clear.
  - WSTRB=0 still completes with OKAY and no change.
- Write latency: AW and W together at edge N gives BVALID=1 after edge N.
- BVALID holds until BVALID&BREADY. While BVALID=1, no AW or W is accepted, so at most one write is outstanding.
- Read path:
  - ARREADY = !ARESET & !RVALID.
  - On an AR handshake, RDATA <= shadow[ARADDR[3:2]] and RVALID <= 1.
  - RDATA/RVALID stay stable until RVALID&RREADY; RVALID then clears on that edge.
- Read and write channels operate concurrently. A read and a write to the same register committing in the same cycle: the read returns the pre-write value.
- Frame commit: on an edge with i_frame_start=1, all active registers load the pre-edge shadow values and o_cfg_updated=1 for the following cycle.
  - A write committing on the same edge reaches the active set at the next frame_start.
  - i_frame_start during ARESET is ignored.
- o_cfg is always registered and never changes except on a frame commit or reset.

Decomposition:
- Package vp_cfg_pkg holds:
  - register index constants: REG_CTRL=0, REG_THRESH=1, REG_KERNEL=2, REG_AUX=3
  - AXI response constant RESP_OKAY=2'b00
  - typedef cfg_word_t (logic [31:0])
  - typedef cfg_bank_t (cfg_word_t [3:0])
- One sub-module, vp_axil_wr_join: the AW/W held-flag join and B-response handshake, producing a one-cycle write-commit strobe with address, data and strobe.
- Read path, register array and commit logic live in the top module.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses -> RDATA 0x1, 0x2, 0x3, 0x4 with BRESP/RRESP=0; o_cfg stays 0 until the first i_frame_start, then equals {0x4,0x3,0x2,0x1} with o_cfg_updated high for one cycle.
- W presented 3 cycles before AW at 0x8 with data 0xDEADBEEF -> WREADY handshake, then stall (WREADY=0); BVALID rises the edge AW handshakes; readback 0xDEADBEEF.
- Shadow 0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
- BREADY held low 10 cycles after a write -> BVALID stays 1, AWREADY/WREADY stay 0, a second AW is not accepted until the B handshake.
- Write 0xAA to 0x4 committing on the same edge as i_frame_start, with active reg1 previously 0x55 -> o_cfg[63:32]=0x55 after that frame; 0xAA after the next i_frame_start.
- ARESET asserted 1 cycle after an AW-only handshake -> no BVALID; all registers and o_cfg read 0; READYs return to 1 the cycle after ARESET deasserts.

Source files
------------

// File: rtl/vp_cfg_pkg.sv
// vp_cfg_pkg: shared types and constants for the videoProcess config register bank.
//   - register index constants and AXI response code
//   - cfg_word_t / cfg_bank_t register types
//   - wr_req_t: one committed write (index, data, byte strobes)
//   - apply_strb(): byte-lane merge of write data into an existing word
package vp_cfg_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_THRESH = 2'd1;
  localparam logic [1:0] REG_KERNEL = 2'd2;
  localparam logic [1:0] REG_AUX    = 2'd3;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef logic [DATA_W-1:0] cfg_word_t;
  typedef cfg_word_t [NUM_REGS-1:0] cfg_bank_t;

  typedef struct packed {
    logic [1:0]        idx;
    cfg_word_t         data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  function automatic cfg_word_t apply_strb(cfg_word_t old_w, cfg_word_t new_w,
                                           logic [STRB_W-1:0] strb);
    cfg_word_t res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/vp_axil_wr_join.sv
// vp_axil_wr_join: joins the independent AXI4-Lite AW and W channels and runs
// the B handshake. Each channel's payload is latched on its handshake and held
// until the partner shows up; the cycle both are available (held or handshaking
// now) produces a one-cycle commit strobe with the merged request.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   awidx_i/awvalid_i/awready_o   write address channel (register index only)
//   wdata_i/wstrb_i/wvalid_i/wready_o   write data channel
//   bvalid_o/bready_i       write response handshake
//   wr_vld_o, wr_o          commit strobe and the write to apply
module vp_axil_wr_join
  import vp_cfg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        awidx_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  cfg_word_t         wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              wr_vld_o,
  output wr_req_t           wr_o
);

  logic              aw_held_q, w_held_q, bvalid_q;
  logic [1:0]        awidx_q;
  cfg_word_t         wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs, commit;

  // BVALID blocks both channels so only one write is ever outstanding.
  assign awready_o = !rst_i && !aw_held_q && !bvalid_q;
  assign wready_o  = !rst_i && !w_held_q  && !bvalid_q;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i  && wready_o;
  assign commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // A channel that is held cannot handshake again, so pick held payload first.
  assign wr_o.idx  = aw_held_q ? awidx_q : awidx_i;
  assign wr_o.data = w_held_q  ? wdata_q : wdata_i;
  assign wr_o.strb = w_held_q  ? wstrb_q : wstrb_i;
  assign wr_vld_o  = commit;
  assign bvalid_o  = bvalid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (bvalid_q && bready_i) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awidx_q   <= awidx_i;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= wdata_i;
          wstrb_q  <= wstrb_i;
        end
      end
    end
  end

endmodule

// File: rtl/vp_axil_cfg_regbank.sv
// vp_axil_cfg_regbank: AXI4-Lite slave holding four 32-bit shadow config
// registers for the videoProcess datapath. Shadows are copied into the active
// set on i_frame_start so the datapath only ever sees frame-coherent config.
// Ports:
//   ACLK, ARESET                    clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*                 write channels (via vp_axil_wr_join)
//   S_AXI_AR*/R*                    read channels, returns shadow values
//   i_frame_start                   frame-start pulse, loads active set
//   o_cfg                           active registers, reg n at [32n+31:32n]
//   o_cfg_updated                   one-cycle pulse after each active load
module vp_axil_cfg_regbank
  import vp_cfg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            i_frame_start,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_cfg,
  output logic                            o_cfg_updated
);

  cfg_bank_t shadow_q, shadow_d, active_q;
  cfg_word_t rdata_q, rdata_d;
  logic      rvalid_q, rvalid_d, upd_q;
  logic      wr_vld, ar_hs;
  wr_req_t   wr;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  vp_axil_wr_join u_wr_join (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .awidx_i   (S_AXI_AWADDR[3:2]),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .wr_vld_o  (wr_vld),
    .wr_o      (wr)
  );

  assign S_AXI_BRESP = RESP_OKAY;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_vld) shadow_d[wr.idx] = apply_strb(shadow_q[wr.idx], wr.data, wr.strb);
  end

  // Read samples shadow_q, so a same-edge write is not yet visible.
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = shadow_q[S_AXI_ARADDR[3:2]];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      shadow_q <= '0;
      active_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      upd_q    <= i_frame_start;
      // Pre-edge shadow: a write committing now waits for the next frame.
      if (i_frame_start) active_q <= shadow_q;
    end
  end

  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign o_cfg         = active_q;
  assign o_cfg_updated = upd_q;

endmodule

// File: tb/tb_vp_axil_cfg_regbank.sv
module tb_vp_axil_cfg_regbank;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [3:0]   S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic         S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
  logic         S_AXI_ARVALID = 0, S_AXI_RREADY = 0, i_frame_start = 0;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0]  S_AXI_RDATA;
  logic [127:0] o_cfg;
  logic         o_cfg_updated;

  always #5 ACLK = ~ACLK;

  vp_axil_cfg_regbank dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .i_frame_start(i_frame_start), .o_cfg(o_cfg), .o_cfg_updated(o_cfg_updated)
  );

  // reference model: plain arrays of words
  logic [31:0] m_shadow [4];
  logic [31:0] m_active [4];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_cfg();
    return {m_active[3], m_active[2], m_active[1], m_active[0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
  endtask

  task automatic b_finish();
    chk("bvalid", S_AXI_BVALID, 1);
    chk("bresp", S_AXI_BRESP, 0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("bvalid_hold", S_AXI_BVALID, 1);
    end
    S_AXI_BREADY = 1; tick(); S_AXI_BREADY = 0;
    chk("bvalid_clr", S_AXI_BVALID, 0);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int  ad, wd, cyc;
    bit  aw_done, w_done, af, wf;
    ad = $urandom_range(0, 3); wd = $urandom_range(0, 3);
    aw_done = 0; w_done = 0; cyc = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done)) begin
      S_AXI_AWVALID = !aw_done && cyc >= ad;
      S_AXI_WVALID  = !w_done && cyc >= wd;
      @(negedge ACLK);
      af = S_AXI_AWVALID && S_AXI_AWREADY;
      wf = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (af) aw_done = 1;
      if (wf) w_done = 1;
      if (!(aw_done && w_done)) chk("bvalid_early", S_AXI_BVALID, 0);
      cyc++;
      if (cyc > 30) begin chk("wr_timeout", 0, 1); break; end
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (aw_done && w_done) begin
      m_shadow[addr[3:2]] = merge(m_shadow[addr[3:2]], data, strb);
      b_finish();
    end
  endtask

  task automatic axi_read(input logic [3:0] addr);
    int  cyc;
    bit  fired;
    logic [31:0] exp;
    repeat ($urandom_range(0, 2)) tick();
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; cyc = 0; fired = 0;
    exp = m_shadow[addr[3:2]];
    while (!fired) begin
      @(negedge ACLK);
      fired = S_AXI_ARREADY;
      tick();
      if (++cyc > 20) begin chk("rd_timeout", 0, 1); break; end
    end
    S_AXI_ARVALID = 0;
    chk("rvalid", S_AXI_RVALID, 1);
    chk("rdata", S_AXI_RDATA, exp);
    chk("rresp", S_AXI_RRESP, 0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("rdata_hold", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, exp});
    end
    S_AXI_RREADY = 1; tick(); S_AXI_RREADY = 0;
    chk("rvalid_clr", S_AXI_RVALID, 0);
  endtask

  task automatic frame();
    i_frame_start = 1;
    for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
    tick();
    i_frame_start = 0;
    chk("cfg_frame", o_cfg, m_cfg());
    chk("upd_pulse", o_cfg_updated, 1);
    tick();
    chk("upd_clr", o_cfg_updated, 0);
  endtask

  task automatic do_reset(input int n);
    ARESET = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      chk("rst_rdy", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
      tick();
    end
    m_reset();
    chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, o_cfg_updated}, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_cfg", o_cfg, 0);
    ARESET = 0;
    @(negedge ACLK);
    chk("post_rst_rdy", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    tick();
  endtask

  initial begin
    m_reset();
    tick();
    do_reset(3);

    // sequential writes then reads; active set untouched until a frame
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    chk("cfg_before_frame", o_cfg, 0);
    frame();
    chk("cfg_seq", o_cfg, {32'h4, 32'h3, 32'h2, 32'h1});

    // W three cycles ahead of AW
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    @(negedge ACLK); chk("wfirst_wready", S_AXI_WREADY, 1);
    tick(); S_AXI_WVALID = 0;
    repeat (2) begin
      @(negedge ACLK);
      chk("wfirst_stall", {S_AXI_WREADY, S_AXI_BVALID}, 0);
      tick();
    end
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1;
    @(negedge ACLK); chk("wfirst_awready", S_AXI_AWREADY, 1);
    tick(); S_AXI_AWVALID = 0;
    m_shadow[2] = 32'hDEADBEEF;
    b_finish();
    axi_read(4'h8);

    // byte strobes
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
    axi_write(4'h4, 32'h00000000, 4'b0101);
    axi_read(4'h4);
    chk("strb_model", m_shadow[1], 32'hFF00FF00);
    axi_write(4'hC, 32'h12345678, 4'h0);
    axi_read(4'hC);

    // BREADY held low: second write must wait for the B handshake
    axi_write(4'h0, 32'hA5A5A5A5, 4'hF);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0F0F0F0F; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(negedge ACLK);
    chk("stall_ready0", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    tick();
    m_shadow[0] = 32'h0F0F0F0F;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h11111111;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("stall_b", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      tick();
    end
    S_AXI_BREADY = 1; tick(); S_AXI_BREADY = 0;
    chk("stall_bclr", S_AXI_BVALID, 0);
    @(negedge ACLK);
    chk("stall_accept", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    m_shadow[1] = 32'h11111111;
    b_finish();
    axi_read(4'h0);
    axi_read(4'h4);

    // read and write to same register on one edge: read sees the old value
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'hE;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    chk("rw_same_rdata", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, m_shadow[3]});
    m_shadow[3] = 32'hCAFEF00D;
    S_AXI_RREADY = 1;
    b_finish();
    S_AXI_RREADY = 0;
    axi_read(4'hC);

    // write committing on the same edge as frame_start
    axi_write(4'h4, 32'h55, 4'hF);
    frame();
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hAA; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; i_frame_start = 1;
    for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; i_frame_start = 0;
    m_shadow[1] = 32'hAA;
    chk("same_edge_old", o_cfg[63:32], 32'h55);
    chk("same_edge_upd", o_cfg_updated, 1);
    b_finish();
    frame();
    chk("same_edge_new", o_cfg[63:32], 32'hAA);

    // reset after an AW-only handshake abandons the write
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1;
    tick(); S_AXI_AWVALID = 0;
    i_frame_start = 1;
    do_reset(2);
    i_frame_start = 0;
    chk("rst_mid_bvalid", S_AXI_BVALID, 0);
    tick();
    chk("rst_frame_ignored", o_cfg, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    S_AXI_WDATA = 32'h77; S_AXI_WVALID = 1;
    tick(); S_AXI_WVALID = 0;
    tick();
    chk("rst_aw_dropped", S_AXI_BVALID, 0);
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1;
    tick(); S_AXI_AWVALID = 0;
    m_shadow[2] = 32'h77;
    b_finish();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 1: axi_write(4'($urandom), $urandom, 4'($urandom));
        2:    axi_read(4'($urandom));
        default: frame();
      endcase
    end
    frame();
    chk("final_cfg", o_cfg, m_cfg());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
